shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
Sequencer that converts parallel words into a serial bit stream. It owns an internal WIDTH-bit shift register and accepts words over a valid/ready handshake. It then emits them one bit per accepted serial handshake and signals completion. It sits between a parallel producer (PIPO-style register stage) and a serial sink, and gives the shift-register datapath its load/shift/idle sequencing.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset; asserted low clears all state immediately
in_data  input  WIDTH  parallel word from producer
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is valid
ser_ready  input  1  sink accepts ser_out this cycle
ser_last  output  1  current serial bit is the final bit of the frame
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after the final bit is accepted

Behaviour:
- Reset (reset low, async): state=IDLE, shift reg=0, bit count=0. Outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0, done=0. in_ready=1 is asserted only after reset deasserts.
- States: IDLE, SHIFT, DONE. Registered state; outputs decoded from state and registers only. No combinational path from in_valid/ser_ready to any output.
- IDLE: in_ready=1. When in_valid&&in_ready at a clock edge: capture in_data, set bit count to 0, go to SHIFT.
- SHIFT: in_ready=0, busy=1, ser_valid=1. ser_out = shift reg bit WIDTH-1 when MSB_FIRST=1, else bit 0.
- On each edge with ser_valid&&ser_ready: shift by one toward the output end, zero-fill, and increment the count.
- When ser_ready=0: ser_out, count and shift reg hold. The stall may last any number of cycles.
- ser_last=1 while the count equals FRAME-1. FRAME = WIDTH without the optional feature.
- Handshake on the last bit: go to DONE.
- DONE: one cycle. done=1, busy=1, ser_valid=0, in_ready=0. Next edge goes to IDLE.
- First bit appears the cycle after acceptance. Minimum frame period is FRAME+2 cycles (accept, FRAME bits, DONE).
- in_data/in_valid are ignored outside IDLE; no buffering of a second word.
- Count width is clog2(FRAME+1). Count never exceeds FRAME-1.
- Reset asserted mid-frame aborts immediately. No done pulse; partial frame is discarded.

Optional Feature:
Macro SHIFT_CTRL_PARITY_EN.
- Defined: FRAME = WIDTH+1. The parity bit (XOR of all WIDTH captured bits, giving even parity) is computed at capture and sent as the final bit. ser_last accompanies the parity bit, not the last data bit.
- Undefined: FRAME = WIDTH, no parity logic is synthesized, and ser_last accompanies the last data bit.

Test Plan:
- Reset: hold reset low 2 cycles with in_valid=1 -> in_ready/ser_valid/busy/done all 0. The cycle after release, in_ready=1 and no capture has occurred.
- Basic frame, WIDTH=8, MSB_FIRST=1, ser_ready=1: in_data=8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles. ser_last on the 8th bit, done pulses one cycle later, in_ready returns the following cycle.
- LSB-first, MSB_FIRST=0: in_data=8'hF0 -> ser_out 0,0,0,0,1,1,1,1.
- Backpressure: in_data=8'h3C with ser_ready low for 3 cycles after bit 2 -> ser_out and ser_last hold and no bits are lost. The full sequence 0,0,1,1,1,1,0,0 still arrives. done follows the final handshake.
- Busy rejection and abort: second in_valid with 8'hFF during SHIFT is ignored. Driving reset low after 4 bits of 8'hAA -> outputs clear at once with no done. The next frame 8'h81 sends 1,0,0,0,0,0,0,1.
- SHIFT_CTRL_PARITY_EN defined: 8'hA5 -> 9 bits, data then parity 0. 8'hA4 -> parity bit 1. ser_last is on the 9th bit only.

Source files
------------

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - parallel-to-serial shift sequencer with valid/ready on both sides
//
// Accepts a WIDTH-bit word over in_valid/in_ready, then emits it one bit per
// ser_valid/ser_ready handshake, flags the final bit with ser_last and pulses
// done for one cycle after the final handshake.
//
// Parameters:
//   WIDTH      data word width (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Optional build macro:
//   SHIFT_CTRL_PARITY_EN  appends an even-parity bit as the final serial bit
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_data    parallel word from producer
//   in_valid   producer offers in_data
//   in_ready   controller can take a word (IDLE and out of reset)
//   ser_out    current serial bit
//   ser_valid  ser_out is valid
//   ser_ready  sink takes ser_out this cycle
//   ser_last   ser_out is the final bit of the frame
//   busy       frame in progress
//   done       one-cycle pulse after the final bit is taken
module shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

`ifdef SHIFT_CTRL_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [FRAME-1:0] sreg;
  logic [FRAME-1:0] frame_word;
  logic [CW-1:0]    cnt;
  logic             armed;
  logic             accept;
  logic             step;

  // The parity bit (when enabled) sits at the far end of the register from
  // the output so it naturally leaves last.
  always_comb begin
`ifdef SHIFT_CTRL_PARITY_EN
    if (MSB_FIRST) frame_word = {in_data, ^in_data};
    else           frame_word = {^in_data, in_data};
`else
    frame_word = in_data;
`endif
  end

  // armed keeps in_ready low while reset is held and rises on the first edge
  // after release, so a word held on in_valid across reset is not captured.
  assign in_ready  = armed && (state == IDLE);
  assign busy      = (state != IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_last  = (state == SHIFT) && (cnt == LAST);
  assign done      = (state == DONE);
  assign ser_out   = (state == SHIFT) && (MSB_FIRST ? sreg[FRAME-1] : sreg[0]);

  assign accept = in_valid && in_ready;
  assign step   = (state == SHIFT) && ser_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (step && (cnt == LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= frame_word;
      cnt  <= '0;
    end else if (step) begin
      if (MSB_FIRST) sreg <= {sreg[FRAME-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[FRAME-1:1]};
      // Wrap to zero on the final bit so the count never exceeds FRAME-1.
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - self-checking bench for shift_ctrl (MSB-first and LSB-first instances)
module tb_shift_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_ready;
  logic       sel;

  logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m, done_m;
  logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l, done_l;
  logic in_valid_m, in_valid_l;
  logic in_ready_o, ser_out_o, ser_valid_o, ser_last_o, busy_o, done_o;

  int n_chk;
  int n_fail;

  assign in_valid_m = in_valid && !sel;
  assign in_valid_l = in_valid && sel;

  assign in_ready_o  = sel ? in_ready_l  : in_ready_m;
  assign ser_out_o   = sel ? ser_out_l   : ser_out_m;
  assign ser_valid_o = sel ? ser_valid_l : ser_valid_m;
  assign ser_last_o  = sel ? ser_last_l  : ser_last_m;
  assign busy_o      = sel ? busy_l      : busy_m;
  assign done_o      = sel ? done_l      : done_m;

  shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_m),
    .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
    .ser_ready(ser_ready), .ser_last(ser_last_m), .busy(busy_m), .done(done_m)
  );

  shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_l),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
    .ser_ready(ser_ready), .ser_last(ser_last_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the frame is the word read from the chosen end, followed by
  // an even-parity bit when that build option is on.
  task automatic run_frame(input logic [7:0] word, input bit lsb,
                           input int stall_at, input int stall_len, input bit rnd);
    logic exp_bits[$];
    int   i;
    int   stalls;
    int   ones;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      exp_bits.push_back(lsb ? word[k] : word[7-k]);
      ones += int'(word[k]);
    end
`ifdef SHIFT_CTRL_PARITY_EN
    exp_bits.push_back(ones % 2 == 1);
`endif
    sel       = lsb;
    ser_ready = 1'b0;
    chk("idle_in_ready", in_ready_o, 1);
    chk("idle_busy", busy_o, 0);
    in_data  = word;
    in_valid = 1'b1;
    @(negedge clk);
    // A second word offered during the frame must be ignored.
    in_data  = ~word;
    in_valid = 1'b1;
    i = 0;
    stalls = 0;
    while (i < exp_bits.size()) begin
      chk("shift_ser_valid", ser_valid_o, 1);
      chk("shift_ser_out", ser_out_o, exp_bits[i]);
      chk("shift_ser_last", ser_last_o, (i == exp_bits.size() - 1));
      chk("shift_busy", busy_o, 1);
      chk("shift_in_ready", in_ready_o, 0);
      chk("shift_done", done_o, 0);
      if (rnd) ser_ready = ($urandom_range(0, 3) != 0) || (stalls >= 3);
      else     ser_ready = !((i == stall_at) && (stalls < stall_len));
      if (ser_ready) begin
        i++;
        stalls = 0;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    ser_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("done_busy", busy_o, 1);
    chk("done_ser_valid", ser_valid_o, 0);
    chk("done_in_ready", in_ready_o, 0);
    @(negedge clk);
    chk("post_done", done_o, 0);
    chk("post_in_ready", in_ready_o, 1);
    chk("post_busy", busy_o, 0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    sel       = 1'b0;
    reset     = 1'b0;
    in_data   = 8'h55;
    in_valid  = 1'b1;
    ser_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_ser_valid", ser_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ser_out", ser_out_o, 0);
    chk("rst_ser_last", ser_last_o, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready_o, 1);
    chk("rel_no_capture", busy_o, 0);
    in_valid = 1'b0;

    run_frame(8'hA5, 1'b0, -1, 0, 1'b0);
    run_frame(8'hF0, 1'b1, -1, 0, 1'b0);
    run_frame(8'h3C, 1'b0, 2, 3, 1'b0);
    run_frame(8'h3C, 1'b1, 5, 2, 1'b0);

    // Abort mid-frame: four bits of 8'hAA, then reset.
    sel      = 1'b0;
    in_data  = 8'hAA;
    in_valid = 1'b1;
    @(negedge clk);
    in_data   = 8'hFF;
    ser_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("abort_bits", ser_out_o, k % 2 == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_ser_valid", ser_valid_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_in_ready", in_ready_o, 0);
    chk("abort_ser_out", ser_out_o, 0);
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done_o, 0);
    reset = 1'b1;
    @(negedge clk);
    run_frame(8'h81, 1'b0, -1, 0, 1'b0);

`ifdef SHIFT_CTRL_PARITY_EN
    run_frame(8'hA5, 1'b0, -1, 0, 1'b0);
    run_frame(8'hA4, 1'b0, -1, 0, 1'b0);
    run_frame(8'hA4, 1'b1, 3, 2, 1'b0);
`endif

    for (int r = 0; r < 24; r++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
